arb_mux_4_1: RTL and testbench

ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

---
 rtl/arb_pkg.sv | 20 ++
 rtl/mux_4_1.sv | 19 +
 rtl/arb_mux_4_1.sv | 63 ++++++
 tb/tb_arb_mux_4_1.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared requester count, index type and round-robin pick for arb_mux_4_1
package arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t LAST_RST = 2'd3;

    // Searches last+1, last+2, last+3, last (mod 4); the nearest valid requester wins.
    function automatic req_idx_t rr_pick(input logic [N_REQ-1:0] v, input req_idx_t last);
        req_idx_t g;
        g = last;
        for (int k = N_REQ; k >= 1; k--) begin
            if (v[last + req_idx_t'(k)]) g = last + req_idx_t'(k);
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// mux_4_1: W-bit 4:1 multiplexer
module mux_4_1
    import arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  req_idx_t     sel_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);
    end

endmodule

// File: rtl/arb_mux_4_1.sv
// arb_mux_4_1: round-robin arbiter over four valid/ready requesters feeding a one-entry output register
module arb_mux_4_1
    import arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic [N_REQ-1:0] in_valid,
    output logic [N_REQ-1:0] in_ready,
    output logic [W-1:0]     out_data,
    output req_idx_t         out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0] out_data_q, out_data_d, mux_y;
    req_idx_t     out_src_q, out_src_d, last_q, last_d, grant;
    logic         out_valid_q, out_valid_d, en;

    mux_4_1 #(.W(W)) u_mux (
        .d0_i (d0),
        .d1_i (d1),
        .d2_i (d2),
        .d3_i (d3),
        .sel_i(grant),
        .y_o  (mux_y)
    );

    // The register accepts a new item when empty or when its current item leaves this cycle.
    always_comb begin
        grant       = rr_pick(in_valid, last_q);
        en          = !rst && (|in_valid) && (!out_valid_q || out_ready);
        in_ready    = en ? (N_REQ'(1) << grant) : '0;
        out_valid_d = en || (out_valid_q && !out_ready);
        out_data_d  = en ? mux_y : out_data_q;
        out_src_d   = en ? grant : out_src_q;
        last_d      = en ? grant : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            last_q      <= LAST_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_4_1.sv
// tb_arb_mux_4_1: scoreboard bench with a round-robin reference model, directed cases and random stress
module tb_arb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [5:0] sb_q[$];
    bit         mdl_full = 0;
    int         mdl_last = 3;

    arb_mux_4_1 #(.W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare in_ready/out_valid with the model, and record accepted items.
    task automatic step(input logic r, input logic [3:0] iv, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] e, input logic ordy);
        logic [3:0] dv[4];
        logic [3:0] exp_ir;
        bit         en;
        int         g;
        @(negedge clk);
        rst = r; in_valid = iv; d0 = a; d1 = b; d2 = c; d3 = e; out_ready = ordy;
        dv = '{a, b, c, e};
        #1;
        en = !r && (iv != 0) && (!mdl_full || ordy);
        g = -1;
        for (int k = 1; k <= 4; k++) begin
            if (g < 0 && iv[(mdl_last + k) % 4]) g = (mdl_last + k) % 4;
        end
        exp_ir = en ? (4'b0001 << g) : 4'b0000;
        check("in_ready", int'(in_ready), int'(exp_ir));
        if (!r) check("out_valid", int'(out_valid), int'(mdl_full));
        if (r) begin
            mdl_full = 0;
            mdl_last = 3;
            sb_q.delete();
        end else if (en) begin
            sb_q.push_back({2'(g), dv[g]});
            mdl_last = g;
            mdl_full = 1;
        end else if (mdl_full && ordy) begin
            mdl_full = 0;
        end
    endtask

    // Monitor: pops an expected item on every output transfer and checks stall stability.
    bit         prev_stall = 0;
    logic [3:0] prev_data;
    logic [1:0] prev_src;
    initial begin
        logic [5:0] exp_item;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(prev_data));
                    check("stall_src", int'(out_src), int'(prev_src));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_item", 1, 0);
                    end else begin
                        exp_item = sb_q.pop_front();
                        check("sb_src", int'(out_src), int'(exp_item[5:4]));
                        check("sb_data", int'(out_data), int'(exp_item[3:0]));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_src   = out_src;
            end
        end
    end

    initial begin
        step(1, 4'b0000, 0, 0, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_src", int'(out_src), 0);
        check("rst_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, 1, 2, 3, 4, 1);
            @(posedge clk); #1;
            check("rr_src", int'(out_src), i % 4);
            check("rr_data", int'(out_data), i % 4 + 1);
        end
        step(0, 4'b0000, 0, 0, 0, 0, 1);
        step(0, 4'b0100, 0, 0, 4'hA, 0, 1);
        @(posedge clk); #1;
        check("single_valid", int'(out_valid), 1);
        check("single_data", int'(out_data), 10);
        check("single_src", int'(out_src), 2);
        for (int i = 0; i < 3; i++) step(0, 4'b0011, 5, 6, 7, 8, 0);
        step(0, 4'b0011, 5, 6, 7, 8, 1);
        @(posedge clk); #1;
        check("stall_resume_src", int'(out_src), 0);
        step(0, 4'b0011, 5, 6, 7, 8, 1);
        @(posedge clk); #1;
        check("stall_next_src", int'(out_src), 1);
        step(1, 4'b0000, 0, 0, 0, 0, 1);
        step(0, 4'b1000, 0, 0, 0, 9, 1);
        @(posedge clk); #1;
        check("wrap_src3", int'(out_src), 3);
        step(0, 4'b1111, 1, 2, 3, 4, 0);
        @(posedge clk); #1;
        check("wrap_hold_src", int'(out_src), 3);
        step(0, 4'b1111, 1, 2, 3, 4, 1);
        @(posedge clk); #1;
        check("wrap_src0", int'(out_src), 0);
        step(0, 4'b1111, 1, 2, 3, 4, 0);
        step(1, 4'b1111, 1, 2, 3, 4, 0);
        @(posedge clk); #1;
        check("midrst_valid", int'(out_valid), 0);
        step(0, 4'b1111, 1, 2, 3, 4, 1);
        @(posedge clk); #1;
        check("midrst_src", int'(out_src), 0);
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 99) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 0, 0, 0, 0, 1);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
